// File: rtl/time_keeper.sv
// time_keeper: packed-BCD time-of-day counter with a RUN/SET mode.
// Seconds advance on sec_tick in RUN. In SET, inc_min and inc_hr adjust the
// time directly and seconds are held at 00. day_tick marks the midnight
// rollover. All outputs come straight from registers.
module time_keeper #(
    parameter bit MODE_24H = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic       pm,
    output logic       day_tick
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    localparam logic [7:0] HR_RESET = MODE_24H ? 8'h00 : 8'h12;

    state_t     state_reg;
    logic [7:0] sec_reg;
    logic [7:0] min_reg;
    logic [7:0] hr_reg;
    logic       pm_reg;
    logic       day_tick_reg;

    // Next-value candidates for each field, computed digit by digit.
    logic [7:0] sec_next;
    logic [7:0] min_next;
    logic [7:0] hr_next;
    logic       pm_next;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_midnight;

    // Advance a 00..59 BCD value: units carry into tens, and 59 wraps to 00.
    function automatic logic [7:0] inc_sexa(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                return 8'h00;
            else
                return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Advance hours. Returns {pm, hours}. In 12h mode, 11 -> 12 flips pm and
    // 12 -> 01. In 24h mode, 23 -> 00 and pm passes through unchanged.
    function automatic logic [8:0] inc_hour(input logic [7:0] v, input logic p);
        if (MODE_24H) begin
            if (v == 8'h23)
                return {p, 8'h00};
            else if (v[3:0] == 4'd9)
                return {p, v[7:4] + 4'd1, 4'd0};
            else
                return {p, v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h12)
                return {p, 8'h01};
            else if (v == 8'h11)
                return {~p, 8'h12};
            else if (v[3:0] == 4'd9)
                return {p, v[7:4] + 4'd1, 4'd0};
            else
                return {p, v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Compute increment candidates and carry/midnight conditions.
    always_comb begin
        sec_next           = inc_sexa(sec_reg);
        min_next           = inc_sexa(min_reg);
        {pm_next, hr_next} = inc_hour(hr_reg, pm_reg);
        sec_wrap           = (sec_reg == 8'h59);
        min_wrap           = (min_reg == 8'h59);
        // The hour rollover that lands on the start of a new day.
        hr_midnight        = MODE_24H ? (hr_reg == 8'h23) : ((hr_reg == 8'h11) && pm_reg);
    end

    // Mode FSM plus all time registers. A mode change always wins over
    // sec_tick on the same edge, so that tick is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            sec_reg      <= 8'h00;
            min_reg      <= 8'h00;
            hr_reg       <= HR_RESET;
            pm_reg       <= 1'b0;
            day_tick_reg <= 1'b0;
        end else begin
            day_tick_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (set_mode) begin
                        state_reg <= ST_SET;
                        sec_reg   <= 8'h00;
                    end else if (sec_tick) begin
                        sec_reg <= sec_next;
                        if (sec_wrap) begin
                            min_reg <= min_next;
                            if (min_wrap) begin
                                hr_reg       <= hr_next;
                                pm_reg       <= pm_next;
                                day_tick_reg <= hr_midnight;
                            end
                        end
                    end
                end
                ST_SET: begin
                    if (!set_mode)
                        state_reg <= ST_RUN;
                    sec_reg <= 8'h00;
                    if (inc_min)
                        min_reg <= min_next;
                    if (inc_hr) begin
                        hr_reg <= hr_next;
                        pm_reg <= pm_next;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign sec_bcd  = sec_reg;
    assign min_bcd  = min_reg;
    assign hr_bcd   = hr_reg;
    assign pm       = pm_reg;
    assign day_tick = day_tick_reg;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed checks of time_keeper.
// Instance 0 runs in 24h mode and instance 1 runs in 12h mode.
// Both instances share clk and rst_n. Each instance has its own control inputs.
module tb_time_keeper;

    logic       clk;
    logic       rst_n;
    logic       sec_tick_v [2];
    logic       set_mode_v [2];
    logic       inc_min_v  [2];
    logic       inc_hr_v   [2];
    logic [7:0] sec_w      [2];
    logic [7:0] min_w      [2];
    logic [7:0] hr_w       [2];
    logic       pm_w       [2];
    logic       day_w      [2];

    int n_checks = 0;
    int n_fail   = 0;

    time_keeper #(.MODE_24H(1'b1)) u_dut24 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_tick (sec_tick_v[0]),
        .set_mode (set_mode_v[0]),
        .inc_min  (inc_min_v[0]),
        .inc_hr   (inc_hr_v[0]),
        .sec_bcd  (sec_w[0]),
        .min_bcd  (min_w[0]),
        .hr_bcd   (hr_w[0]),
        .pm       (pm_w[0]),
        .day_tick (day_w[0])
    );

    time_keeper #(.MODE_24H(1'b0)) u_dut12 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_tick (sec_tick_v[1]),
        .set_mode (set_mode_v[1]),
        .inc_min  (inc_min_v[1]),
        .inc_hr   (inc_hr_v[1]),
        .sec_bcd  (sec_w[1]),
        .min_bcd  (min_w[1]),
        .hr_bcd   (hr_w[1]),
        .pm       (pm_w[1]),
        .day_tick (day_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the visible time as {pm, hh, mm, ss} so one hex constant states it.
    function automatic logic [31:0] snap(input int d);
        return {7'd0, pm_w[d], hr_w[d], min_w[d], sec_w[d]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Hold sec_tick high for n consecutive edges.
    task automatic tick_n(input int d, input int n);
        sec_tick_v[d] = 1'b1;
        repeat (n) @(negedge clk);
        sec_tick_v[d] = 1'b0;
    endtask

    // Enter SET, apply n_hr hour pulses and n_min minute pulses, then return to RUN.
    task automatic set_time(input int d, input int n_hr, input int n_min);
        set_mode_v[d] = 1'b1;
        @(negedge clk);
        inc_hr_v[d] = 1'b1;
        repeat (n_hr) @(negedge clk);
        inc_hr_v[d] = 1'b0;
        inc_min_v[d] = 1'b1;
        repeat (n_min) @(negedge clk);
        inc_min_v[d] = 1'b0;
        set_mode_v[d] = 1'b0;
        @(negedge clk);
    endtask

    function automatic bit bcd_ok(input int d);
        return (sec_w[d][3:0] <= 4'd9) && (sec_w[d][7:4] <= 4'd5) &&
               (min_w[d][3:0] <= 4'd9) && (min_w[d][7:4] <= 4'd5) &&
               (hr_w[d][3:0]  <= 4'd9) && (hr_w[d][7:4]  <= 4'd2);
    endfunction

    initial begin
        int bad;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sec_tick_v[i] = 1'b0;
            set_mode_v[i] = 1'b0;
            inc_min_v[i]  = 1'b0;
            inc_hr_v[i]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values for both modes.
        check_eq("rst24_time", snap(0), 32'h0000_0000);
        check_eq("rst24_day",  {31'd0, day_w[0]}, 32'd0);
        check_eq("rst12_time", snap(1), 32'h0012_0000);

        // Asynchronous reset in the middle of a count.
        set_time(0, 5, 17);
        tick_n(0, 33);
        check_eq("pre_rst_time", snap(0), 32'h0005_1733);
        #1 rst_n = 1'b0;
        #1 check_eq("async_rst_time", snap(0), 32'h0000_0000);
        check_eq("async_rst_day", {31'd0, day_w[0]}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 24h midnight rollover.
        set_time(0, 23, 59);
        tick_n(0, 59);
        check_eq("r24_235959", snap(0), 32'h0023_5959);
        check_eq("r24_day_lo", {31'd0, day_w[0]}, 32'd0);
        tick_n(0, 1);
        check_eq("r24_midnight", snap(0), 32'h0000_0000);
        check_eq("r24_day_hi", {31'd0, day_w[0]}, 32'd1);
        @(negedge clk);
        check_eq("r24_day_1cyc", {31'd0, day_w[0]}, 32'd0);

        // 12h transitions: AM to PM, 12 to 01, and PM to AM at midnight.
        set_time(1, 11, 59);
        tick_n(1, 59);
        check_eq("h12_1159_am", snap(1), 32'h0011_5959);
        tick_n(1, 1);
        check_eq("h12_noon", snap(1), 32'h0112_0000);
        check_eq("h12_noon_day", {31'd0, day_w[1]}, 32'd0);
        set_time(1, 0, 59);
        tick_n(1, 59);
        check_eq("h12_1259", snap(1), 32'h0112_5959);
        tick_n(1, 1);
        check_eq("h12_0100", snap(1), 32'h0101_0000);
        set_time(1, 10, 59);
        tick_n(1, 59);
        check_eq("h12_1159_pm", snap(1), 32'h0111_5959);
        tick_n(1, 1);
        check_eq("h12_midnight", snap(1), 32'h0012_0000);
        check_eq("h12_mid_day", {31'd0, day_w[1]}, 32'd1);

        // SET mode: minute wrap without hour carry, ticks ignored, and both increments together.
        do_reset();
        set_mode_v[0] = 1'b1;
        @(negedge clk);
        inc_min_v[0] = 1'b1;
        repeat (61) @(negedge clk);
        inc_min_v[0] = 1'b0;
        check_eq("set_61min", snap(0), 32'h0000_0100);
        tick_n(0, 10);
        check_eq("set_ticks_ign", snap(0), 32'h0000_0100);
        inc_min_v[0] = 1'b1;
        repeat (58) @(negedge clk);
        inc_min_v[0] = 1'b0;
        inc_hr_v[0] = 1'b1;
        repeat (9) @(negedge clk);
        inc_hr_v[0] = 1'b0;
        check_eq("set_0959", snap(0), 32'h0009_5900);
        inc_hr_v[0] = 1'b1;
        inc_min_v[0] = 1'b1;
        @(negedge clk);
        inc_hr_v[0] = 1'b0;
        inc_min_v[0] = 1'b0;
        check_eq("set_both_1000", snap(0), 32'h0010_0000);
        check_eq("set_no_day", {31'd0, day_w[0]}, 32'd0);
        set_mode_v[0] = 1'b0;
        @(negedge clk);
        inc_hr_v[0] = 1'b1;
        inc_min_v[0] = 1'b1;
        @(negedge clk);
        inc_hr_v[0] = 1'b0;
        inc_min_v[0] = 1'b0;
        check_eq("run_inc_ign", snap(0), 32'h0010_0000);

        // A sec_tick on the RUN->SET edge is dropped and seconds are cleared.
        do_reset();
        tick_n(0, 58);
        check_eq("col_0058", snap(0), 32'h0000_0058);
        sec_tick_v[0] = 1'b1;
        set_mode_v[0] = 1'b1;
        @(negedge clk);
        sec_tick_v[0] = 1'b0;
        check_eq("col_cleared", snap(0), 32'h0000_0000);
        tick_n(0, 3);
        check_eq("col_in_set", snap(0), 32'h0000_0000);
        set_mode_v[0] = 1'b0;
        @(negedge clk);
        tick_n(0, 1);
        check_eq("col_resume", snap(0), 32'h0000_0001);

        // Back-to-back ticks, with every nibble checked on every cycle.
        do_reset();
        bad = 0;
        sec_tick_v[0] = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!bcd_ok(0))
                bad++;
        end
        sec_tick_v[0] = 1'b0;
        check_eq("b2b_bcd_valid", bad, 32'd0);
        check_eq("b2b_0200", snap(0), 32'h0000_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
